// File: rtl/cordic_step_sequencer_pkg.sv
// Shared CORDIC types and constants: rotation mode, FSM states and the
// hyperbolic repeat schedule (repeats at 4, 13, 40, ... with rep' = 3*rep+1).
package pa_AsyncCordic;

    localparam int RW        = 14;
    localparam int REP_FIRST = 4;
    localparam int REP_MUL   = 3;

    typedef enum logic {CIRC, HYPER} mode_e;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

endpackage

// File: rtl/cordic_step_sequencer_if.sv
// Control and step-handshake bundle between the CORDIC step sequencer
// and its datapath consumer.
interface cordic_step_sequencer_if
    import pa_AsyncCordic::*;
#(
    parameter int SHIFT_W = 5,
    parameter int IDX_W   = 4
);
    logic               start_i;
    mode_e              mode_i;
    logic               abort_i;
    logic               step_valid_o;
    logic               step_ready_i;
    logic [SHIFT_W-1:0] shift_o;
    logic [IDX_W-1:0]   step_idx_o;
    logic               repeat_o;
    logic               last_o;
    logic               busy_o;
    logic               done_o;

    modport slave (
        input  start_i, mode_i, abort_i, step_ready_i,
        output step_valid_o, shift_o, step_idx_o, repeat_o, last_o, busy_o, done_o
    );

    modport master (
        output start_i, mode_i, abort_i, step_ready_i,
        input  step_valid_o, shift_o, step_idx_o, repeat_o, last_o, busy_o, done_o
    );
endinterface

// File: rtl/cordic_shift_schedule.sv
// Combinational next-step schedule: the shift amount, repeat register and
// repeat flag that follow the current step.
module cordic_shift_schedule
    import pa_AsyncCordic::*;
#(
    parameter int SHIFT_W = 5
) (
    input  mode_e              mode_i,
    input  logic [SHIFT_W-1:0] shift_i,
    input  logic [SHIFT_W+1:0] rep_i,
    input  logic               repeat_i,
    output logic [SHIFT_W-1:0] shift_o,
    output logic [SHIFT_W+1:0] rep_o,
    output logic               repeat_o
);

    // rep is compared at full width, so once it exceeds the largest reachable
    // shift no further repeats occur and 3*rep+1 can never wrap.
    always_comb begin
        shift_o  = shift_i + SHIFT_W'(1);
        rep_o    = rep_i;
        repeat_o = 1'b0;
        if (mode_i == HYPER && {2'b00, shift_i} == rep_i && !repeat_i) begin
            shift_o  = shift_i;
            repeat_o = 1'b1;
            rep_o    = (SHIFT_W+2)'(rep_i * (SHIFT_W+2)'(REP_MUL) + (SHIFT_W+2)'(1));
        end
    end

endmodule

// File: rtl/cordic_step_sequencer.sv
// CORDIC iteration sequencer: presents one micro-rotation step per
// valid/ready handshake, with start/abort control and a done pulse.
module cordic_step_sequencer
    import pa_AsyncCordic::*;
#(
    parameter int ITERS   = RW + 2,
    parameter int SHIFT_W = $clog2(ITERS + 1),
    parameter int IDX_W   = $clog2(ITERS)
) (
    input  logic                    clk,
    input  logic                    arst,
    cordic_step_sequencer_if.slave  bus
);

    state_e             state_q, state_d;
    logic [SHIFT_W-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [SHIFT_W+1:0] rep_q, rep_d;
    logic               repeat_q, repeat_d;
    mode_e              mode_q, mode_d;

    logic [SHIFT_W-1:0] nxtShift;
    logic [SHIFT_W+1:0] nxtRep;
    logic               nxtRepeat;
    logic               last;

    cordic_shift_schedule #(.SHIFT_W(SHIFT_W)) u_schedule (
        .mode_i   (mode_q),
        .shift_i  (shift_q),
        .rep_i    (rep_q),
        .repeat_i (repeat_q),
        .shift_o  (nxtShift),
        .rep_o    (nxtRep),
        .repeat_o (nxtRepeat)
    );

    assign last = (idx_q == IDX_W'(ITERS - 1));

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            idx_q    <= '0;
            rep_q    <= (SHIFT_W+2)'(REP_FIRST);
            repeat_q <= 1'b0;
            mode_q   <= CIRC;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            idx_q    <= idx_d;
            rep_q    <= rep_d;
            repeat_q <= repeat_d;
            mode_q   <= mode_d;
        end
    end

    // Abort takes priority over both start in IDLE and any handshake in RUN.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        idx_d    = idx_q;
        rep_d    = rep_q;
        repeat_d = repeat_q;
        mode_d   = mode_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start_i && !bus.abort_i) begin
                    state_d  = RUN;
                    shift_d  = (bus.mode_i == HYPER) ? SHIFT_W'(1) : '0;
                    idx_d    = '0;
                    rep_d    = (SHIFT_W+2)'(REP_FIRST);
                    repeat_d = 1'b0;
                    mode_d   = bus.mode_i;
                end
            end
            RUN: begin
                if (bus.abort_i) begin
                    state_d = IDLE;
                end else if (bus.step_ready_i) begin
                    if (last) begin
                        state_d = DONE;
                    end else begin
                        idx_d    = idx_q + IDX_W'(1);
                        shift_d  = nxtShift;
                        rep_d    = nxtRep;
                        repeat_d = nxtRepeat;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.step_valid_o = (state_q == RUN);
    assign bus.busy_o       = (state_q == RUN) || (state_q == DONE);
    assign bus.done_o       = (state_q == DONE);
    assign bus.shift_o      = shift_q;
    assign bus.step_idx_o   = idx_q;
    assign bus.repeat_o     = repeat_q;
    assign bus.last_o       = last;

endmodule

// File: tb/tb_cordic_step_sequencer.sv
// Directed self-checking bench for cordic_step_sequencer with three
// instances (HYPER ITERS=6, CIRC ITERS=4, default ITERS=16).
module tb_cordic_step_sequencer;
    import pa_AsyncCordic::*;

    localparam int N0 = 6;
    localparam int N1 = 4;
    localparam int N2 = 16;
    localparam int S0 = $clog2(N0 + 1);
    localparam int I0 = $clog2(N0);
    localparam int S1 = $clog2(N1 + 1);
    localparam int I1 = $clog2(N1);
    localparam int S2 = $clog2(N2 + 1);
    localparam int I2 = $clog2(N2);

    logic  clk = 1'b0;
    logic  arst = 1'b1;
    logic  start = 1'b0;
    logic  abort = 1'b0;
    logic  ready = 1'b1;
    mode_e mode = CIRC;
    int    sel = 0;

    int checks = 0;
    int failures = 0;

    int h6[16]  = '{1, 2, 3, 4, 4, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    int c4[16]  = '{0, 1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    int h16[16] = '{1, 2, 3, 4, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 13, 14};

    always #5 clk = ~clk;

    cordic_step_sequencer_if #(.SHIFT_W(S0), .IDX_W(I0)) bus0 ();
    cordic_step_sequencer_if #(.SHIFT_W(S1), .IDX_W(I1)) bus1 ();
    cordic_step_sequencer_if #(.SHIFT_W(S2), .IDX_W(I2)) bus2 ();

    assign bus0.start_i = start && (sel == 0);
    assign bus1.start_i = start && (sel == 1);
    assign bus2.start_i = start && (sel == 2);
    assign bus0.mode_i = mode;
    assign bus1.mode_i = mode;
    assign bus2.mode_i = mode;
    assign bus0.abort_i = abort;
    assign bus1.abort_i = abort;
    assign bus2.abort_i = abort;
    assign bus0.step_ready_i = ready;
    assign bus1.step_ready_i = ready;
    assign bus2.step_ready_i = ready;

    cordic_step_sequencer #(.ITERS(N0)) dut0 (.clk(clk), .arst(arst), .bus(bus0.slave));
    cordic_step_sequencer #(.ITERS(N1)) dut1 (.clk(clk), .arst(arst), .bus(bus1.slave));
    cordic_step_sequencer               dut2 (.clk(clk), .arst(arst), .bus(bus2.slave));

    logic [31:0] oValid, oShift, oIdx, oRep, oLast, oBusy, oDone;

    // View of whichever instance the current test is driving.
    always_comb begin
        oValid = 32'(bus0.step_valid_o);
        oShift = 32'(bus0.shift_o);
        oIdx   = 32'(bus0.step_idx_o);
        oRep   = 32'(bus0.repeat_o);
        oLast  = 32'(bus0.last_o);
        oBusy  = 32'(bus0.busy_o);
        oDone  = 32'(bus0.done_o);
        if (sel == 1) begin
            oValid = 32'(bus1.step_valid_o);
            oShift = 32'(bus1.shift_o);
            oIdx   = 32'(bus1.step_idx_o);
            oRep   = 32'(bus1.repeat_o);
            oLast  = 32'(bus1.last_o);
            oBusy  = 32'(bus1.busy_o);
            oDone  = 32'(bus1.done_o);
        end else if (sel == 2) begin
            oValid = 32'(bus2.step_valid_o);
            oShift = 32'(bus2.shift_o);
            oIdx   = 32'(bus2.step_idx_o);
            oRep   = 32'(bus2.repeat_o);
            oLast  = 32'(bus2.last_o);
            oBusy  = 32'(bus2.busy_o);
            oDone  = 32'(bus2.done_o);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed %0d expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int which, input mode_e m);
        sel   = which;
        mode  = m;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Walks a full run with ready high; optionally pulses start (mode CIRC)
    // at step injectIdx to show it is ignored while busy.
    task automatic runSequence(input int len, input int shifts[16], input logic [15:0] repMask, input int injectIdx);
        for (int i = 0; i < len; i++) begin
            checkOutput($sformatf("valid[%0d]", i), oValid, 1);
            checkOutput($sformatf("shift[%0d]", i), oShift, 32'(shifts[i]));
            checkOutput($sformatf("idx[%0d]", i), oIdx, 32'(i));
            checkOutput($sformatf("repeat[%0d]", i), oRep, 32'(repMask[i]));
            checkOutput($sformatf("last[%0d]", i), oLast, 32'(i == len - 1));
            checkOutput($sformatf("busy[%0d]", i), oBusy, 1);
            checkOutput($sformatf("doneEarly[%0d]", i), oDone, 0);
            if (i == injectIdx) begin
                start = 1'b1;
                mode  = CIRC;
            end
            tick();
            start = 1'b0;
        end
        checkOutput("donePulse", oDone, 1);
        checkOutput("validInDone", oValid, 0);
        checkOutput("busyInDone", oBusy, 1);
        tick();
        checkOutput("doneCleared", oDone, 0);
        checkOutput("busyCleared", oBusy, 0);
        checkOutput("validIdle", oValid, 0);
    endtask

    initial begin
        $display("[TB] reset");
        #12;
        sel = 0;
        checkOutput("rstValid", oValid, 0);
        checkOutput("rstShift", oShift, 0);
        checkOutput("rstIdx", oIdx, 0);
        checkOutput("rstRepeat", oRep, 0);
        checkOutput("rstLast", oLast, 0);
        checkOutput("rstBusy", oBusy, 0);
        checkOutput("rstDone", oDone, 0);
        tick();
        arst = 1'b0;
        tick();

        $display("[TB] HYPER ITERS=6");
        applyStimulus(0, HYPER);
        runSequence(N0, h6, 16'h0010, -1);

        $display("[TB] CIRC ITERS=4 and restart");
        applyStimulus(1, CIRC);
        runSequence(N1, c4, 16'h0000, -1);
        applyStimulus(1, CIRC);
        runSequence(N1, c4, 16'h0000, -1);

        $display("[TB] abort and start together in IDLE");
        sel   = 1;
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        checkOutput("abortStartValid", oValid, 0);
        checkOutput("abortStartBusy", oBusy, 0);

        $display("[TB] abort beats last handshake");
        applyStimulus(1, CIRC);
        tick();
        tick();
        tick();
        checkOutput("atLastIdx", oIdx, 3);
        checkOutput("atLastFlag", oLast, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("abortLastDone", oDone, 0);
        checkOutput("abortLastBusy", oBusy, 0);
        tick();
        checkOutput("abortLastDoneLater", oDone, 0);

        $display("[TB] HYPER ITERS=16 with ignored mid-run start");
        applyStimulus(2, HYPER);
        runSequence(N2, h16, 16'h4010, 1);

        $display("[TB] backpressure then abort");
        applyStimulus(2, HYPER);
        tick();
        tick();
        checkOutput("bpIdx", oIdx, 2);
        checkOutput("bpShift", oShift, 3);
        ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput($sformatf("bpHoldIdx[%0d]", k), oIdx, 2);
            checkOutput($sformatf("bpHoldShift[%0d]", k), oShift, 3);
            checkOutput($sformatf("bpHoldValid[%0d]", k), oValid, 1);
        end
        ready = 1'b1;
        tick();
        checkOutput("bpResumeIdx", oIdx, 3);
        checkOutput("bpResumeShift", oShift, 4);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("abortValid", oValid, 0);
        checkOutput("abortBusy", oBusy, 0);
        checkOutput("abortDone", oDone, 0);
        tick();
        checkOutput("abortDoneLater", oDone, 0);

        $display("[TB] reset mid-run");
        applyStimulus(0, HYPER);
        tick();
        tick();
        checkOutput("preRstIdx", oIdx, 2);
        arst = 1'b1;
        #1;
        checkOutput("midRstValid", oValid, 0);
        checkOutput("midRstShift", oShift, 0);
        checkOutput("midRstIdx", oIdx, 0);
        checkOutput("midRstBusy", oBusy, 0);
        checkOutput("midRstRepeat", oRep, 0);
        checkOutput("midRstLast", oLast, 0);
        tick();
        arst = 1'b0;
        tick();
        applyStimulus(0, HYPER);
        runSequence(N0, h6, 16'h0010, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
